bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter that feeds the seven-segment decoder. Takes a BW-bit unsigned binary value on a start strobe, runs an iterative shift-and-add-3 (double dabble) conversion one bit per clock, and presents two packed BCD digits on `bcd`. `bcd` drives the decoder's 8-bit `addr` input directly: tens in [7:4], units in [3:0]. The result is held stable between conversions so the display multiplexer always sees a settled value.

## Interface
- `BW`, 7: width of binary input; legal range 4..10.
- `AW`, 8: output width; fixed at two BCD digits and must equal the decoder's `AW`.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a conversion; sampled on the rising edge of `clk`.
- `bin`  in  BW: unsigned binary operand; captured on the accepted `start` edge.
- `busy`  out  1: high while a conversion is in progress.
- `done`  out  1: single-cycle pulse when `bcd` and `ovf` update.
- `bcd`  out  AW: packed BCD result (tens:units); holds its value until the next `done`.
- `ovf`  out  1: set when the converted value is greater than 99; valid from `done` until the next `done`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, or DONE, with `start`=1: capture `bin` into the operand shift register, clear the 12-bit scratch register (hundreds:tens:units), clear the iteration counter, go to SHIFT.
- SHIFT, each cycle:
  - every scratch nibble that is 5 or more gets 3 added;
  - then {scratch, operand} shifts left by 1;
  - the counter increments.
  - After BW iterations, go to DONE.
- Entering DONE: update `bcd` and `ovf` from the scratch register; pulse `done`.
- DONE with `start`=0 returns to IDLE.
- `start` while in SHIFT is ignored; no queuing.
- `busy` = 1 only in SHIFT.
- Scratch is 12 bits so that inputs up to 1023 convert exactly.
- `ovf` = 1 when the hundreds nibble is non-zero.
- Reset: state IDLE, `busy`=0, `done`=0, `bcd`=8'h00, `ovf`=0, scratch and counter cleared. Reset in mid-conversion discards that conversion; no `done` is produced.

## Timing
- Let E0 be the edge that samples `start`=1. SHIFT iterations occur on E1..E_BW.
- `done`=1, with the new `bcd`/`ovf`, is visible in the cycle following edge E_BW. For BW=7 that is 8 cycles after the cycle in which `start` was asserted.
- `busy` is high in the cycles after E0 through after E_(BW-1), and low in the `done` cycle.
- Back-to-back: `start` held high in the `done` cycle is accepted, giving one conversion every BW+1 cycles.
- `bcd` changes only on the `done` cycle; it never shows intermediate scratch values.

## Configuration
- `BIN2BCD_CLAMP_EN` defined: when `ovf`=1, `bcd` is forced to 8'h99, so the display saturates.
- Not defined: `bcd` carries the low two digits (value mod 100); `ovf` still asserts.

## Structure
- Shared package `bin2bcd_pkg`:
  - FSM state enum (IDLE/SHIFT/DONE);
  - `BCD_DIGITS`=3 (scratch digits);
  - `BCD_CLAMP`=8'h99;
  - `BCD_ADJ_THRESH`=4'd5.
- One sub-module: `bcd_digit_adjust`, a combinational add-3-if-5-or-more for one nibble, instantiated three times in the SHIFT datapath.

## Test plan
- Reset, then `bin`=42 with a 1-cycle `start` -> `busy` high for 7 cycles; `done` pulse 8 cycles after `start`; `bcd`=8'h42, `ovf`=0.
- `bin`=0, then `bin`=99 -> `bcd`=8'h00, then 8'h99; `ovf`=0 for both.
- `bin`=127 -> `ovf`=1. With `BIN2BCD_CLAMP_EN`: `bcd`=8'h99. Without it: `bcd`=8'h27.
- `bin`=42 accepted, then `start` with `bin`=17 on the 3rd `busy` cycle -> the second request is ignored; one `done`; `bcd`=8'h42.
- `reset` asserted on the 4th cycle of a conversion of 56 -> no `done`; `bcd` stays 8'h00; a fresh `start` with 56 then gives `bcd`=8'h56.
- `start` held high continuously with `bin` stepping 10, 20, 30 -> a `done` pulse every 8 cycles; `bcd` = 8'h10, 8'h20, 8'h30 in order.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int       BCD_DIGITS     = 3;
    localparam int       SCR_W          = 4 * BCD_DIGITS;
    localparam int       CNT_W          = 4;
    localparam bit [7:0] BCD_CLAMP      = 8'h99;
    localparam bit [3:0] BCD_ADJ_THRESH = 4'd5;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/operand request and BCD result bundle between a requester and bin2bcd_seq.
interface bin2bcd_seq_if #(
    parameter int BW = 7,
    parameter int AW = 8
);
    logic          start;
    logic [BW-1:0] bin;
    logic          busy;
    logic          done;
    logic [AW-1:0] bcd;
    logic          ovf;

    modport master (output start, bin, input busy, done, bcd, ovf);
    modport slave  (input start, bin, output busy, done, bcd, ovf);
endinterface

// File: rtl/bin2bcd_seq_digit_adjust.sv
// One double-dabble correction step: add 3 to a BCD nibble that is 5 or more.
module bcd_digit_adjust
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);
    assign adjusted = (digit >= BCD_ADJ_THRESH) ? digit + 4'd3 : digit;
endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one operand bit per clock.
// Optional BIN2BCD_CLAMP_EN: saturate bcd to 99 when the value exceeds 99.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BW = 7,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);

    state_t              state_reg, state_next;
    logic [BW-1:0]       operand_reg, operand_next;
    logic [SCR_W-1:0]    scratch_reg, scratch_next;
    logic [SCR_W-1:0]    scratch_adj;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [AW-1:0]       bcd_reg, bcd_next;
    logic                ovf_reg, ovf_next;
    logic [SCR_W+BW-1:0] shift_vec;
    logic [AW-1:0]       result_bcd;
    logic                result_ovf;

    genvar gi;
    generate
        for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit    (scratch_reg[gi*4 +: 4]),
                .adjusted (scratch_adj[gi*4 +: 4])
            );
        end
    endgenerate

    // Adjust happens before the shift, so the result is taken from the shifted vector.
    assign shift_vec  = {scratch_adj, operand_reg} << 1;
    assign result_ovf = |shift_vec[SCR_W+BW-1 : BW+8];

`ifdef BIN2BCD_CLAMP_EN
    assign result_bcd = result_ovf ? AW'(BCD_CLAMP) : shift_vec[BW +: AW];
`else
    assign result_bcd = shift_vec[BW +: AW];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            operand_reg <= '0;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            bcd_reg     <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            operand_reg <= operand_next;
            scratch_reg <= scratch_next;
            cnt_reg     <= cnt_next;
            bcd_reg     <= bcd_next;
            ovf_reg     <= ovf_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        operand_next = operand_reg;
        scratch_next = scratch_reg;
        cnt_next     = cnt_reg;
        bcd_next     = bcd_reg;
        ovf_next     = ovf_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    operand_next = bus.bin;
                    scratch_next = '0;
                    cnt_next     = '0;
                    state_next   = SHIFT;
                end else begin
                    state_next   = IDLE;
                end
            end
            SHIFT: begin
                scratch_next = shift_vec[SCR_W+BW-1 : BW];
                operand_next = shift_vec[BW-1:0];
                cnt_next     = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(BW - 1)) begin
                    state_next = DONE;
                    bcd_next   = result_bcd;
                    ovf_next   = result_ovf;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state_reg == SHIFT);
    assign bus.done = (state_reg == DONE);
    assign bus.bcd  = bcd_reg;
    assign bus.ovf  = ovf_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq with a result scoreboard checked on each done pulse.
module tb_bin2bcd_seq;

    localparam int BW = 7;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.BW(BW), .AW(AW)) bus ();

    bin2bcd_seq #(.BW(BW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, bcd} computed arithmetically from the decimal value.
    function automatic logic [8:0] model(input int v);
        int lo;
        logic [7:0] b;
        lo = v % 100;
        b  = {4'(lo / 10), 4'(lo % 10)};
`ifdef BIN2BCD_CLAMP_EN
        if (v > 99) b = 8'h99;
`endif
        return {(v > 99), b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until done is seen; returns cycles elapsed and busy cycles observed.
    task automatic wait_done(input bit drop, output int cyc, output int busy_n);
        cyc = 0;
        busy_n = 0;
        do begin
            if (bus.busy === 1'b1) busy_n++;
            tick();
            cyc++;
            if (drop) bus.start = 1'b0;
        end while (bus.done !== 1'b1 && cyc < 40);
    endtask

    task automatic do_conv(input int v);
        int cyc, busy_n;
        bus.start = 1'b1;
        bus.bin   = BW'(v);
        exp_q.push_back(model(v));
        wait_done(1'b1, cyc, busy_n);
        check($sformatf("latency_%0d", v), cyc, BW + 1);
        check($sformatf("busy_cycles_%0d", v), busy_n, BW);
        check($sformatf("busy_in_done_%0d", v), int'(bus.busy), 0);
        tick();
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (bus.done === 1'b1) begin
            done_cnt++;
            total++;
            assert (exp_q.size() != 0)
            else begin
                bad++;
                $error("FAIL unexpected_done: got done with %0d queued expected >0", exp_q.size());
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("done_bcd", int'(bus.bcd), int'(e[7:0]));
                check("done_ovf", int'(bus.ovf), int'(e[8]));
                $display("done: bcd=%02h ovf=%0b expected bcd=%02h ovf=%0b", bus.bcd, bus.ovf, e[7:0], e[8]);
            end
        end
    end

    initial begin
        int cyc, busy_n, d0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (3) tick();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_bcd",  int'(bus.bcd), 0);
        check("rst_ovf",  int'(bus.ovf), 0);
        reset = 1'b0;
        tick();

        do_conv(42);
        do_conv(0);
        do_conv(99);
        do_conv(127);
        check("bcd_held_after_done", int'(bus.bcd), int'(model(127) & 9'h0FF));

        // Start during SHIFT on the third busy cycle is ignored.
        d0 = done_cnt;
        bus.start = 1'b1;
        bus.bin   = BW'(42);
        exp_q.push_back(model(42));
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1;
        bus.bin   = BW'(17);
        wait_done(1'b1, cyc, busy_n);
        check("ignored_start_latency", cyc, 5);
        repeat (12) tick();
        check("ignored_start_one_done", done_cnt - d0, 1);

        // Reset in the middle of a conversion discards it.
        d0 = done_cnt;
        bus.start = 1'b1;
        bus.bin   = BW'(56);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (12) tick();
        check("midreset_no_done", done_cnt - d0, 0);
        check("midreset_bcd", int'(bus.bcd), 0);
        do_conv(56);

        // Back-to-back with start held high.
        bus.start = 1'b1;
        bus.bin   = BW'(10);
        exp_q.push_back(model(10));
        exp_q.push_back(model(20));
        exp_q.push_back(model(30));
        wait_done(1'b0, cyc, busy_n);
        check("b2b_period_0", cyc, BW + 1);
        bus.bin = BW'(20);
        wait_done(1'b0, cyc, busy_n);
        check("b2b_period_1", cyc, BW + 1);
        bus.bin = BW'(30);
        wait_done(1'b0, cyc, busy_n);
        check("b2b_period_2", cyc, BW + 1);
        bus.start = 1'b0;
        repeat (3) tick();

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
